soc_periph_arbiter: RTL and testbench

//   Round-robin arbiter and address decoder that shares the single-outstanding SoC peripheral

---
 rtl/soc_periph_arbiter.sv | 168 ++++++++++++++++
 tb/tb_soc_periph_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/soc_periph_arbiter.sv
// Round-robin arbiter sharing one single-outstanding peripheral port between NumReq requesters.
// Granted addresses are decoded against the SoC memory map; misses and timeouts get a local error.
module soc_periph_arbiter #(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq-1:0]             req_we_i,
  input  logic [NumReq*DataWidth-1:0]   req_wdata_i,
  output logic [NumReq-1:0]             rsp_valid_o,
  output logic [DataWidth-1:0]          rsp_rdata_o,
  output logic                          rsp_err_o,
  output logic                          periph_req_o,
  output logic [3:0]                    periph_sel_o,
  output logic [AddrWidth-1:0]          periph_addr_o,
  output logic                          periph_we_o,
  output logic [DataWidth-1:0]          periph_wdata_o,
  input  logic                          periph_ack_i,
  input  logic [DataWidth-1:0]          periph_rdata_i,
  input  logic                          periph_err_i
);

  localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntW   = $clog2(TimeoutCycles);
  localparam int unsigned NumSlv = 11;

  // Index order: DRAM, GPIO, Ethernet, SPI, Timer, UART, PLIC, CLINT, ROM, Scratch, Debug
  localparam logic [63:0] SlvBase [NumSlv] = '{
    64'h8000_0000, 64'h4000_0000, 64'h3000_0000, 64'h2000_0000, 64'h1800_0000, 64'h1000_0000,
    64'h0C00_0000, 64'h0200_0000, 64'h0001_0000, 64'h1900_0000, 64'h0000_0000};
  localparam logic [63:0] SlvLen [NumSlv] = '{
    64'h4000_0000, 64'h0000_1000, 64'h0001_0000, 64'h0080_0000, 64'h0000_1000, 64'h0000_1000,
    64'h03FF_FFFF, 64'h000C_0000, 64'h0001_0000, 64'h0000_1000, 64'h0000_1000};

  typedef enum logic [1:0] {Idle, Issue, Resp} state_e;

  state_e                 state_q;
  logic [IdxW-1:0]        rr_q, owner_q;
  logic [CntW-1:0]        cnt_q;
  logic                   periph_req_q, we_q, err_q;
  logic [3:0]             sel_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [DataWidth-1:0]   wdata_q, rdata_q;
  logic [NumReq-1:0]      rsp_valid_q;

  logic                   gnt_found;
  logic [IdxW-1:0]        gnt_idx;
  int unsigned            cand;
  logic [AddrWidth-1:0]   gnt_addr;
  logic [DataWidth-1:0]   gnt_wdata;
  logic [63:0]            addr64;
  logic [3:0]             hits;
  logic [3:0]             dec_sel;
  logic                   dec_hit;

  // First valid requester at or after the round-robin pointer
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = (32'(rr_q) + k) % NumReq;
      if (!gnt_found && req_valid_i[IdxW'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IdxW'(cand);
      end
    end
  end

  assign gnt_addr  = req_addr_i[32'(gnt_idx)*AddrWidth +: AddrWidth];
  assign gnt_wdata = req_wdata_i[32'(gnt_idx)*DataWidth +: DataWidth];

  // A hit requires exactly one matching window; limits are summed in 64 bits
  always_comb begin
    addr64  = 64'(gnt_addr);
    hits    = '0;
    dec_sel = '0;
    for (int unsigned s = 0; s < NumSlv; s++) begin
      if (addr64 >= SlvBase[s] && addr64 < (SlvBase[s] + SlvLen[s])) begin
        hits    = hits + 4'd1;
        dec_sel = 4'(s);
      end
    end
    dec_hit = (hits == 4'd1);
  end

  assign req_ready_o = (state_q == Idle && gnt_found && !rst_i) ?
                       (NumReq'(1) << gnt_idx) : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= Idle;
      rr_q         <= '0;
      owner_q      <= '0;
      cnt_q        <= '0;
      periph_req_q <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      sel_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      rsp_valid_q  <= '0;
    end else begin
      case (state_q)
        Idle: begin
          if (gnt_found) begin
            owner_q <= gnt_idx;
            addr_q  <= gnt_addr;
            we_q    <= req_we_i[gnt_idx];
            wdata_q <= gnt_wdata;
            sel_q   <= dec_sel;
            cnt_q   <= '0;
            rr_q    <= (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + IdxW'(1);
            if (dec_hit) begin
              periph_req_q <= 1'b1;
              state_q      <= Issue;
            end else begin
              err_q       <= 1'b1;
              rdata_q     <= '0;
              rsp_valid_q <= NumReq'(1) << gnt_idx;
              state_q     <= Resp;
            end
          end
        end
        Issue: begin
          if (periph_ack_i) begin
            periph_req_q <= 1'b0;
            rdata_q      <= periph_rdata_i;
            err_q        <= periph_err_i;
            rsp_valid_q  <= NumReq'(1) << owner_q;
            state_q      <= Resp;
          end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
            periph_req_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b1;
            rsp_valid_q  <= NumReq'(1) << owner_q;
            state_q      <= Resp;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        Resp: begin
          rsp_valid_q <= '0;
          cnt_q       <= '0;
          state_q     <= Idle;
        end
        default: state_q <= Idle;
      endcase
    end
  end

  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdata_o    = rdata_q;
  assign rsp_err_o      = err_q;
  assign periph_req_o   = periph_req_q;
  assign periph_sel_o   = sel_q;
  assign periph_addr_o  = addr_q;
  assign periph_we_o    = we_q;
  assign periph_wdata_o = wdata_q;

endmodule

// File: tb/tb_soc_periph_arbiter.sv
// Directed bench for soc_periph_arbiter: arbitration order, decode, errors, timeout and reset.
module tb_soc_periph_arbiter;
  localparam int unsigned NR = 2;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned TO = 1024;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_ready, req_we, rsp_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [DW-1:0]     rsp_rdata, periph_wdata, periph_rdata;
  logic              rsp_err, periph_req, periph_we, periph_ack, periph_err;
  logic [3:0]        periph_sel;
  logic [AW-1:0]     periph_addr;

  int total = 0;
  int bad   = 0;
  int n;

  soc_periph_arbiter #(.NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .periph_req_o(periph_req), .periph_sel_o(periph_sel), .periph_addr_o(periph_addr),
    .periph_we_o(periph_we), .periph_wdata_o(periph_wdata),
    .periph_ack_i(periph_ack), .periph_rdata_i(periph_rdata), .periph_err_i(periph_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int r);
    oh = NR'(1) << r;
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic [63:0] a, input logic w, input logic [63:0] d);
    req_valid[r]          = 1'b1;
    req_addr[r*AW +: AW]  = a;
    req_we[r]             = w;
    req_wdata[r*DW +: DW] = d;
  endtask

  // One isolated transaction from requester r, acked on the first ISSUE cycle when decoded
  task automatic run_txn(input string tag, input int r, input logic [63:0] a, input logic w,
                         input logic [63:0] d, input logic hit, input logic [3:0] sel,
                         input logic [63:0] rd, input logic perr);
    req_valid = '0;
    set_req(r, a, w, d);
    #1 check({tag, "_ready"}, 64'(req_ready), 64'(oh(r)));
    tick;
    req_valid = '0;
    if (hit) begin
      check({tag, "_preq"}, 64'(periph_req), 64'd1);
      check({tag, "_sel"}, 64'(periph_sel), 64'(sel));
      check({tag, "_addr"}, periph_addr, a);
      check({tag, "_we"}, 64'(periph_we), 64'(w));
      if (w) check({tag, "_wdata"}, periph_wdata, d);
      periph_ack = 1'b1; periph_rdata = rd; periph_err = perr;
      tick;
      periph_ack = 1'b0;
      check({tag, "_rsp"}, 64'(rsp_valid), 64'(oh(r)));
      check({tag, "_rdata"}, rsp_rdata, rd);
      check({tag, "_err"}, 64'(rsp_err), 64'(perr));
    end else begin
      check({tag, "_nopreq"}, 64'(periph_req), 64'd0);
      check({tag, "_rsp"}, 64'(rsp_valid), 64'(oh(r)));
      check({tag, "_err"}, 64'(rsp_err), 64'd1);
      check({tag, "_rdata"}, rsp_rdata, 64'd0);
    end
    tick;
    check({tag, "_idle"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0; req_we = '0; req_wdata = '0;
    periph_ack = 1'b0; periph_rdata = '0; periph_err = 1'b0;
    set_req(0, 64'h1000_0000, 1'b0, 64'd0);
    set_req(1, 64'h1000_0000, 1'b0, 64'd0);
    tick;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_rsp", 64'(rsp_valid), 64'd0);
    check("rst_preq", 64'(periph_req), 64'd0);
    check("rst_sel", 64'(periph_sel), 64'd0);
    check("rst_addr", periph_addr, 64'd0);
    rst = 1'b0;

    // Both requesters valid: expect alternating grants 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      #1 check("rr_ready", 64'(req_ready), 64'(oh(i % 2)));
      tick;
      check("rr_preq", 64'(periph_req), 64'd1);
      check("rr_sel", 64'(periph_sel), 64'd5);
      check("rr_busy_ready", 64'(req_ready), 64'd0);
      tick;
      periph_ack = 1'b1; periph_rdata = 64'h100 + 64'(i);
      tick;
      periph_ack = 1'b0;
      check("rr_rsp", 64'(rsp_valid), 64'(oh(i % 2)));
      check("rr_rdata", rsp_rdata, 64'h100 + 64'(i));
      check("rr_err", 64'(rsp_err), 64'd0);
      tick;
    end
    req_valid = '0;

    run_txn("unmapped", 0, 64'h0000_2000, 1'b0, 64'd0, 1'b0, 4'd0, 64'd0, 1'b0);
    run_txn("dram_wr", 1, 64'h8000_0000, 1'b1, 64'hDEAD_BEEF, 1'b1, 4'd0, 64'd0, 1'b0);
    run_txn("dram_top", 0, 64'hBFFF_FFFF, 1'b0, 64'd0, 1'b1, 4'd0, 64'h1234, 1'b0);
    run_txn("dram_end", 1, 64'hC000_0000, 1'b0, 64'd0, 1'b0, 4'd0, 64'd0, 1'b0);
    run_txn("scratch", 0, 64'h1900_0FFF, 1'b0, 64'd0, 1'b1, 4'd9, 64'h99, 1'b0);
    run_txn("gpio_err", 1, 64'h4000_0010, 1'b0, 64'd0, 1'b1, 4'd1, 64'hABCD, 1'b1);
    run_txn("debug", 0, 64'h0000_0FFF, 1'b0, 64'd0, 1'b1, 4'd10, 64'h7, 1'b0);

    // Timeout: no ack for TO cycles
    req_valid = '0;
    set_req(0, 64'h1000_0008, 1'b0, 64'd0);
    tick;
    req_valid = '0;
    n = 0;
    while (periph_req && n < 2000) begin
      n++;
      tick;
    end
    check("to_len", 64'(n), 64'(TO));
    check("to_rsp", 64'(rsp_valid), 64'(oh(0)));
    check("to_err", 64'(rsp_err), 64'd1);
    check("to_rdata", rsp_rdata, 64'd0);
    tick;
    periph_ack = 1'b1; periph_rdata = 64'hFFFF;
    tick;
    periph_ack = 1'b0;
    check("stray_rsp", 64'(rsp_valid), 64'd0);
    check("stray_preq", 64'(periph_req), 64'd0);

    // Ack landing in the final timeout cycle is a normal response
    set_req(1, 64'h1000_0010, 1'b0, 64'd0);
    tick;
    req_valid = '0;
    repeat (TO - 1) tick;
    check("lastack_preq", 64'(periph_req), 64'd1);
    periph_ack = 1'b1; periph_rdata = 64'h55; periph_err = 1'b0;
    tick;
    periph_ack = 1'b0;
    check("lastack_rsp", 64'(rsp_valid), 64'(oh(1)));
    check("lastack_err", 64'(rsp_err), 64'd0);
    check("lastack_rdata", rsp_rdata, 64'h55);
    tick;

    // Reset while ISSUE: outputs clear, response never issued
    set_req(0, 64'h1000_0000, 1'b1, 64'h77);
    tick;
    req_valid = '0;
    check("mid_preq", 64'(periph_req), 64'd1);
    rst = 1'b1;
    #1 check("mid_async", 64'(periph_req), 64'd0);
    tick;
    check("mid_rsp", 64'(rsp_valid), 64'd0);
    check("mid_addr", periph_addr, 64'd0);
    check("mid_we", 64'(periph_we), 64'd0);
    check("mid_wdata", periph_wdata, 64'd0);
    rst = 1'b0;
    periph_ack = 1'b1;
    tick;
    periph_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("post_rst_rsp", 64'(rsp_valid), 64'd0);
      tick;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
